// File: rtl/time_set_controller.sv
// time_set_controller: button-driven hour/minute edit front end for the FND clock.
// Debounces mode/up/down buttons, runs the IDLE -> SET_HOUR -> SET_MIN -> COMMIT
// edit flow, and issues a one-cycle load strobe with the edited time.
// Optional macro AUTO_REPEAT_EN: held up/down buttons auto-step after a delay.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_btn_mode/up/down      : raw asynchronous push buttons, active-high
//   i_hour, i_min           : current time from the time counter
//   o_hour, o_min           : edited time
//   o_load                  : one-cycle load strobe (COMMIT)
//   o_set_active            : editing in progress
//   o_set_field             : 0 = hour, 1 = minute
//   o_blink                 : blink phase of the edited field
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [6:0] i_hour,
  input  logic [6:0] i_min,
  output logic [6:0] o_hour,
  output logic [6:0] o_min,
  output logic       o_load,
  output logic       o_set_active,
  output logic       o_set_field,
  output logic       o_blink
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BL_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned B_MODE = 0;
  localparam int unsigned B_UP   = 1;
  localparam int unsigned B_DOWN = 2;

  typedef enum logic [1:0] {S_IDLE, S_SET_HOUR, S_SET_MIN, S_COMMIT} state_e;

  // ---------------- button path ----------------
  logic [2:0] raw_c;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] level_q, level_d;
  logic [2:0] event_q, event_d;
  logic [2:0] block_q, block_d;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];

  assign raw_c = {i_btn_down, i_btn_up, i_btn_mode};

  // Synchronizer is left unreset so a button held through reset stays visible.
  always_ff @(posedge i_clk) begin
    sync1_q <= raw_c;
    sync2_q <= sync1_q;
  end

  // Stability counter per button; block suppresses the first rise after reset
  // until the button has been seen released.
  always_comb begin
    level_d = level_q;
    event_d = '0;
    block_d = block_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
        if (!level_q[i]) block_d[i] = 1'b0;
      end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt_d[i] = '0;
        level_d[i]  = sync2_q[i];
        event_d[i]  = sync2_q[i] & ~block_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level_q <= '0;
      event_q <= '0;
      block_q <= '1;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      level_q <= level_d;
      event_q <= event_d;
      block_q <= block_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // ---------------- auto repeat ----------------
  logic rpt_up_c, rpt_down_c;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  logic [RP_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_first_q, rpt_first_d;
  logic            rpt_pulse_c;
  logic            held_c;

  // Exactly one of up/down held while editing keeps the repeat timer running.
  assign held_c = ((state_q == S_SET_HOUR) || (state_q == S_SET_MIN)) &&
                  (level_q[B_UP] ^ level_q[B_DOWN]);

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_pulse_c = 1'b0;
    if (event_q[B_UP] || event_q[B_DOWN]) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (held_c) begin
      if (rpt_first_q && (rpt_cnt_q == RP_W'(REPEAT_DELAY - 1))) begin
        rpt_pulse_c = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else if (!rpt_first_q && (rpt_cnt_q == RP_W'(REPEAT_CYCLES - 1))) begin
        rpt_pulse_c = 1'b1;
        rpt_cnt_d   = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RP_W'(1);
      end
    end else begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign rpt_up_c   = rpt_pulse_c & level_q[B_UP];
  assign rpt_down_c = rpt_pulse_c & level_q[B_DOWN];
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_CYCLES)};
  assign rpt_up_c   = 1'b0;
  assign rpt_down_c = 1'b0;
`endif

  // ---------------- edit FSM ----------------
  state_e          state_q, state_d;
  logic [6:0]      hour_q, hour_d, min_q, min_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
  logic            blink_q, blink_d;
  logic            load_q, load_d;
  logic            active_q, active_d;
  logic            field_q, field_d;
  logic            up_c, down_c, step_c, timeout_c, set_d_c, entry_c;

  function automatic logic [6:0] step_val(input logic [6:0] v, input logic up,
                                          input logic [6:0] max_v);
    if (up) return (v >= max_v) ? 7'd0 : v + 7'd1;
    return ((v == 7'd0) || (v > max_v)) ? max_v : v - 7'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    hour_d    = hour_q;
    min_d     = min_q;
    tmo_d     = tmo_q;
    bl_cnt_d  = bl_cnt_q;
    blink_d   = blink_q;
    up_c      = event_q[B_UP] | rpt_up_c;
    down_c    = event_q[B_DOWN] | rpt_down_c;
    step_c    = up_c | down_c;
    timeout_c = (tmo_q == TO_W'(TIMEOUT_CYCLES - 1));

    case (state_q)
      S_IDLE: begin
        if (event_q[B_MODE]) begin
          hour_d  = (i_hour > 7'd23) ? 7'd0 : i_hour;
          min_d   = (i_min > 7'd59) ? 7'd0 : i_min;
          state_d = S_SET_HOUR;
        end
      end
      S_SET_HOUR: begin
        if (event_q[B_MODE]) state_d = S_SET_MIN;
        else if (step_c) begin
          if (up_c ^ down_c) hour_d = step_val(hour_q, up_c, 7'd23);
        end else if (timeout_c) state_d = S_IDLE;
      end
      S_SET_MIN: begin
        if (event_q[B_MODE]) state_d = S_COMMIT;
        else if (step_c) begin
          if (up_c ^ down_c) min_d = step_val(min_q, up_c, 7'd59);
        end else if (timeout_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    set_d_c = (state_d == S_SET_HOUR) || (state_d == S_SET_MIN);
    entry_c = set_d_c && (state_d != state_q);

    // Timeout restarts on SET entry and on any press or repeat step.
    if (!set_d_c) tmo_d = '0;
    else if (entry_c || step_c || event_q[B_MODE]) tmo_d = '0;
    else tmo_d = tmo_q + TO_W'(1);

    // Blink starts high on each SET entry and toggles every BLINK_CYCLES.
    if (!set_d_c) begin
      bl_cnt_d = '0;
      blink_d  = 1'b0;
    end else if (entry_c) begin
      bl_cnt_d = '0;
      blink_d  = 1'b1;
    end else if (bl_cnt_q == BL_W'(BLINK_CYCLES - 1)) begin
      bl_cnt_d = '0;
      blink_d  = ~blink_q;
    end else begin
      bl_cnt_d = bl_cnt_q + BL_W'(1);
    end

    load_d   = (state_d == S_COMMIT);
    active_d = set_d_c;
    field_d  = (state_d == S_SET_MIN);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      hour_q   <= '0;
      min_q    <= '0;
      tmo_q    <= '0;
      bl_cnt_q <= '0;
      blink_q  <= 1'b0;
      load_q   <= 1'b0;
      active_q <= 1'b0;
      field_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      tmo_q    <= tmo_d;
      bl_cnt_q <= bl_cnt_d;
      blink_q  <= blink_d;
      load_q   <= load_d;
      active_q <= active_d;
      field_q  <= field_d;
    end
  end

  assign o_hour       = hour_q;
  assign o_min        = min_q;
  assign o_load       = load_q;
  assign o_set_active = active_q;
  assign o_set_field  = field_q;
  assign o_blink      = blink_q;

endmodule
